gate_vector_driver: RTL
=======================

# gate_vector_driver

Self-checking stimulus driver for the registered `(A|B)&C` gate block. On `start` it sweeps all eight A/B/C input combinations into the gate and samples the gate's registered `Z` output. It compares each sample against the golden value and reports per-vector mismatches, an error count and a pass flag. It sits on the input side of the gate block in the lab top level and forms its initiator/checker pair: its `a_out`/`b_out`/`c_out` drive the gate's A/B/C, and the gate's Z returns on `z_in`.

## Interface
- `HOLD`, default 2: cycles each vector is held on `a_out`/`b_out`/`c_out`. Must satisfy HOLD ≥ LATENCY+1.
- `LATENCY`, default 1: register stages between the driver's outputs and a valid `z_in` (the gate block has 1).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Asserting it (0) clears all state immediately.
- `start` input 1: begin a sweep. Sampled on a rising edge, level-sensitive.
- `z_in` input 1: registered Z from the gate block.
- `a_out`, `b_out`, `c_out` output 1 each: current vector, registered.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep finished; held until the next accepted `start` or reset.
- `pass` output 1: asserted with `done` when `err_count` is 0.
- `err_count` output 4: number of mismatching vectors, range 0..8.
- `err_mask` output 8: bit i set when vector i mismatched.

## Operation
- FSM states: IDLE, DRIVE, DONE.
  - IDLE → DRIVE on `start`=1.
  - DRIVE → DONE after vector 7's compare.
  - DONE → DRIVE on `start`=1.
- Vector index i runs 0..7. `{a_out,b_out,c_out}` = i[2:0], so `a_out` is the MSB.
- Golden value: exp(i) = (a|b)&c. This gives EXPECTED_MASK = 8'hA8, i.e. exp = 1 for i = 3, 5, 7.
- Compare: on the last clock of each vector's hold window, `z_in` is compared with exp(i). On a mismatch, `err_mask[i]` is set and `err_count` is incremented at that same edge.
- On entering DRIVE, `err_count`, `err_mask`, `done` and `pass` are cleared, and vector 0 is driven.
- In IDLE and DONE, `a_out`/`b_out`/`c_out` are driven to 0.
- `start` while `busy` is ignored; it neither restarts nor extends the sweep.
- `pass` is registered. It goes to 1 on the same edge as `done` when the final `err_count` is 0, otherwise it stays 0.

## Timing
- Reset values: state IDLE; `a_out`/`b_out`/`c_out` 0; `busy` 0; `done` 0; `pass` 0; `err_count` 0; `err_mask` 0; hold timer 0; index 0.
- Edge S is the rising edge that samples `start`=1. From edge S:
  - `busy`=1 and vector 0 is present after edge S.
  - Vector k is present from edge S+k·HOLD to edge S+(k+1)·HOLD.
  - Vector k is compared at edge S+(k+1)·HOLD.
- After the compare edge for vector 7 (S+8·HOLD): `busy`=0, `done`=1, and `pass` is valid. Total sweep is 8·HOLD cycles (16 at the defaults).
- Reset mid-sweep: all outputs return to their reset values asynchronously, with no partial `done`. The next sweep requires a fresh `start`.
- Re-arm: `start` held continuously restarts the sweep on the first edge in DONE. `done` then drops and `busy` rises on that edge.

## Structure
- Shared package/header holds:
  - NUM_VECTORS = 8
  - EXPECTED_MASK = 8'hA8
  - state encodings IDLE/DRIVE/DONE (2-bit)
  - golden function exp(i)
- Sub-module `gate_hold_timer`: down-counter of width clog2(HOLD), loaded with HOLD−1 at each vector start. It produces `last_cycle` when the count reaches 0. Everything else lives in `gate_vector_driver`.

## Test plan
- Correct gate block in loop, defaults, `start` pulse: `done`=1 and `pass`=1 at S+16, `err_count`=0, `err_mask`=8'h00, outputs step through 000..111.
- `z_in` tied to 0: `err_count`=3, `err_mask`=8'hA8, `pass`=0.
- `z_in` as inverted gate output: `err_count`=8, `err_mask`=8'hFF, `pass`=0.
- Reset asserted during vector 4: all outputs 0 immediately with no clock, FSM in IDLE. A new `start` gives a full clean sweep ending with `pass`=1.
- `start` re-pulsed at vectors 2 and 6 during a sweep: ignored, `done` still at S+16. `start` in DONE clears the results and restarts.
- HOLD=3, LATENCY=1 with the correct gate block: `done` at S+24, `pass`=1, each vector held exactly 3 cycles.

Source files
------------

// File: rtl/gate_vector_driver_pkg.sv
// Shared definitions for the (A|B)&C gate stimulus driver: vector count,
// golden response mask, FSM state encoding and the golden-value function.
package gate_vector_driver_pkg;

    localparam int unsigned NUM_VECTORS   = 8;
    localparam logic [7:0]  EXPECTED_MASK = 8'hA8;
    localparam logic [2:0]  LAST_IDX      = 3'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Golden response of the gate for vector index idx = {a,b,c}.
    function automatic logic golden_exp(input logic [2:0] idx);
        return (idx[2] | idx[1]) & idx[0];
    endfunction

endpackage

// File: rtl/gate_hold_timer.sv
// Per-vector hold timer: a down-counter loaded with HOLD-1 at the start of
// each vector; last_cycle flags the final clock of the hold window.
module gate_hold_timer #(
    parameter int HOLD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic last_cycle
);

    localparam int          CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = CW'(0);

    logic [CW-1:0] count_r;

    // Count down to zero while enabled; a load restarts the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (enable && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign last_cycle = (count_r == ZERO);

endmodule

// File: rtl/gate_vector_driver.sv
// Stimulus driver / checker for the registered (A|B)&C gate block. On start
// it walks vectors 0..7 onto a/b/c, compares the returned Z on the last clock
// of each hold window against the golden value and reports the results.
module gate_vector_driver
    import gate_vector_driver_pkg::*;
#(
    parameter int HOLD    = 2,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       z_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] err_mask
);

    // A hold window shorter than the return latency could never see a valid
    // Z, so the window is stretched to the minimum that works.
    localparam int HOLD_EFF = (HOLD < (LATENCY + 1)) ? (LATENCY + 1) : HOLD;

    state_t     state_r;
    logic [2:0] idx_r;
    logic [2:0] vec_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [3:0] err_count_r;
    logic [7:0] err_mask_r;

    logic       last_s;
    logic       start_accept_s;
    logic       timer_load_s;
    logic       timer_en_s;
    logic       mismatch_s;
    logic [3:0] err_count_next_s;
    logic [7:0] err_mask_next_s;

    gate_hold_timer #(
        .HOLD (HOLD_EFF)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load_s),
        .enable     (timer_en_s),
        .last_cycle (last_s)
    );

    // Start acceptance, timer control and the running error tally.
    always_comb begin
        start_accept_s   = 1'b0;
        timer_load_s     = 1'b0;
        timer_en_s       = 1'b0;
        mismatch_s       = 1'b0;
        err_count_next_s = err_count_r;
        err_mask_next_s  = err_mask_r;

        if (state_r != DRIVE) begin
            start_accept_s = start;
        end else begin
            start_accept_s = 1'b0;
        end

        if (state_r == DRIVE) begin
            timer_en_s = 1'b1;
            mismatch_s = (z_in != golden_exp(idx_r));
        end else begin
            timer_en_s = 1'b0;
            mismatch_s = 1'b0;
        end

        if (start_accept_s) begin
            timer_load_s = 1'b1;
        end else if ((state_r == DRIVE) && last_s && (idx_r != LAST_IDX)) begin
            timer_load_s = 1'b1;
        end else begin
            timer_load_s = 1'b0;
        end

        if (mismatch_s) begin
            err_count_next_s = err_count_r + 4'd1;
            err_mask_next_s  = err_mask_r | (8'd1 << idx_r);
        end else begin
            err_count_next_s = err_count_r;
            err_mask_next_s  = err_mask_r;
        end
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            idx_r       <= 3'd0;
            vec_r       <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= 4'd0;
            err_mask_r  <= 8'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_accept_s) begin
                        state_r     <= DRIVE;
                        idx_r       <= 3'd0;
                        vec_r       <= 3'd0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        err_count_r <= 4'd0;
                        err_mask_r  <= 8'd0;
                    end else begin
                        vec_r  <= 3'd0;
                        busy_r <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (last_s) begin
                        err_count_r <= err_count_next_s;
                        err_mask_r  <= err_mask_next_s;
                        if (idx_r == LAST_IDX) begin
                            state_r <= DONE;
                            idx_r   <= 3'd0;
                            vec_r   <= 3'd0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_count_next_s == 4'd0);
                        end else begin
                            idx_r <= idx_r + 3'd1;
                            vec_r <= idx_r + 3'd1;
                        end
                    end else begin
                        vec_r <= idx_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= 3'd0;
                    vec_r       <= 3'd0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    pass_r      <= 1'b0;
                    err_count_r <= 4'd0;
                    err_mask_r  <= 8'd0;
                end
            endcase
        end
    end

    assign a_out     = vec_r[2];
    assign b_out     = vec_r[1];
    assign c_out     = vec_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign err_mask  = err_mask_r;

endmodule
